// File: rtl/branch_predictor.sv
// BTB with per-entry saturating direction counters: zero-latency fetch lookup, resolve/train from EX.
// Optional perf counters: define BP_PERF_CTR_EN to build the stat_upd/stat_mispred counters.
module branch_predictor #(
    parameter int DBITS        = 32,
    parameter int INSTSIZE     = 4,
    parameter int BTB_IDX_BITS = 6,
    parameter int CTR_BITS     = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [DBITS-1:0] pc_fe,
    output logic [DBITS-1:0] pcpred_fe,
    output logic             predtaken_fe,
    input  logic             clear,
    input  logic             upd_valid,
    input  logic             upd_is_jmp,
    input  logic [DBITS-1:0] upd_pc,
    input  logic [DBITS-1:0] upd_pcpred,
    input  logic             upd_taken,
    input  logic [DBITS-1:0] upd_target,
    output logic             mispred_ex,
    output logic [DBITS-1:0] pcgood_ex,
    output logic [31:0]      stat_upd,
    output logic [31:0]      stat_mispred
);

    localparam int TAGBITS = DBITS - BTB_IDX_BITS - 2;
    localparam int ENTRIES = 1 << BTB_IDX_BITS;
    localparam logic [CTR_BITS-1:0] CTR_MAX = {CTR_BITS{1'b1}};
    localparam logic [CTR_BITS-1:0] CTR_WT  = CTR_BITS'(1 << (CTR_BITS - 1));
    localparam logic [CTR_BITS-1:0] CTR_WNT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);

    function automatic logic [CTR_BITS-1:0] sat_inc(input logic [CTR_BITS-1:0] c);
        return (c == CTR_MAX) ? c : c + 1'b1;
    endfunction

    function automatic logic [CTR_BITS-1:0] sat_dec(input logic [CTR_BITS-1:0] c);
        return (c == '0) ? c : c - 1'b1;
    endfunction

    logic [ENTRIES-1:0] r_valid;
    logic [TAGBITS-1:0] r_tag    [ENTRIES];
    logic [DBITS-1:0]   r_target [ENTRIES];
    logic [CTR_BITS-1:0] r_ctr   [ENTRIES];

    // Fetch-side lookup
    logic [BTB_IDX_BITS-1:0] w_fe_idx;
    logic [TAGBITS-1:0]      w_fe_tag;
    logic                    w_fe_hit;

    assign w_fe_idx     = pc_fe[BTB_IDX_BITS+1:2];
    assign w_fe_tag     = pc_fe[DBITS-1:BTB_IDX_BITS+2];
    assign w_fe_hit     = r_valid[w_fe_idx] & (r_tag[w_fe_idx] == w_fe_tag);
    assign predtaken_fe = w_fe_hit & r_ctr[w_fe_idx][CTR_BITS-1];
    assign pcpred_fe    = predtaken_fe ? r_target[w_fe_idx] : pc_fe + DBITS'(INSTSIZE);

    // Resolve-side outputs
    logic [BTB_IDX_BITS-1:0] w_ex_idx;
    logic [TAGBITS-1:0]      w_ex_tag;
    logic                    w_ex_hit;

    assign w_ex_idx   = upd_pc[BTB_IDX_BITS+1:2];
    assign w_ex_tag   = upd_pc[DBITS-1:BTB_IDX_BITS+2];
    assign w_ex_hit   = r_valid[w_ex_idx] & (r_tag[w_ex_idx] == w_ex_tag);
    assign pcgood_ex  = upd_taken ? upd_target : upd_pc + DBITS'(INSTSIZE);
    assign mispred_ex = upd_valid & (upd_pcpred != pcgood_ex);

    // Training decisions for the entry addressed by upd_pc
    logic                w_alloc;
    logic                w_wr_tgt;
    logic                w_ctr_we;
    logic [CTR_BITS-1:0] w_ctr_nxt;

    always_comb begin
        w_alloc   = 1'b0;
        w_wr_tgt  = 1'b0;
        w_ctr_we  = 1'b0;
        w_ctr_nxt = r_ctr[w_ex_idx];
        if (upd_valid && !clear) begin
            if (w_ex_hit) begin
                w_ctr_we = 1'b1;
                if (upd_is_jmp) begin
                    w_ctr_nxt = CTR_MAX;
                    w_wr_tgt  = 1'b1;
                end else begin
                    w_ctr_nxt = upd_taken ? sat_inc(r_ctr[w_ex_idx]) : sat_dec(r_ctr[w_ex_idx]);
                    w_wr_tgt  = upd_taken;
                end
            end else if (upd_taken) begin
                w_alloc   = 1'b1;
                w_wr_tgt  = 1'b1;
                w_ctr_we  = 1'b1;
                w_ctr_nxt = upd_is_jmp ? CTR_MAX : CTR_WT;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                r_ctr[i] <= CTR_WNT;
            end
        end else if (clear) begin
            r_valid <= '0;
        end else begin
            if (w_alloc) begin
                r_valid[w_ex_idx] <= 1'b1;
            end
            if (w_ctr_we) begin
                r_ctr[w_ex_idx] <= w_ctr_nxt;
            end
        end
    end

    // Tags and targets are qualified by r_valid, so they need no reset.
    always_ff @(posedge clk) begin
        if (w_wr_tgt) begin
            r_target[w_ex_idx] <= upd_target;
        end
        if (w_alloc) begin
            r_tag[w_ex_idx] <= w_ex_tag;
        end
    end

`ifdef BP_PERF_CTR_EN
    logic [31:0] r_stat_upd;
    logic [31:0] r_stat_mis;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stat_upd <= '0;
            r_stat_mis <= '0;
        end else begin
            if (upd_valid && (r_stat_upd != 32'hFFFF_FFFF)) begin
                r_stat_upd <= r_stat_upd + 32'd1;
            end
            if (mispred_ex && (r_stat_mis != 32'hFFFF_FFFF)) begin
                r_stat_mis <= r_stat_mis + 32'd1;
            end
        end
    end

    assign stat_upd     = r_stat_upd;
    assign stat_mispred = r_stat_mis;
`else
    assign stat_upd     = 32'd0;
    assign stat_mispred = 32'd0;
`endif

    // Byte-offset bits of the PCs play no part in indexing.
    logic w_unused;
    assign w_unused = &{1'b0, pc_fe[1:0], upd_pc[1:0]};

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Parametrised branch target buffer (BTB) with per-entry saturating direction counters for the fetch stage.
- Replaces the fixed "PC + INSTSIZE" next-PC prediction.
- FE looks up the current PC combinationally to get a predicted next PC.
- EX reports each resolved branch/jump; the block flags misprediction, supplies the correct PC and trains its tables.

Parameters:
- DBITS, 32, address/data width.
- INSTSIZE, 4, byte increment for fall-through PC.
- BTB_IDX_BITS, 6, log2 of entry count (64 entries).
- CTR_BITS, 2, width of each saturating direction counter (>=1).

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous active-high reset.
- pc_fe  input  DBITS  PC being fetched.
- pcpred_fe  output  DBITS  predicted next PC.
- predtaken_fe  output  1  prediction is taken (BTB hit with counter MSB=1).
- clear  input  1  synchronous invalidate of all entries.
- upd_valid  input  1  EX has a resolved branch/jump this cycle.
- upd_is_jmp  input  1  resolved op is unconditional (JAL).
- upd_pc  input  DBITS  PC of resolved op.
- upd_pcpred  input  DBITS  next PC that was predicted for it, carried down the pipe.
- upd_taken  input  1  actual direction.
- upd_target  input  DBITS  actual taken target.
- mispred_ex  output  1  prediction was wrong.
- pcgood_ex  output  DBITS  correct next PC.
- stat_upd  output  32  resolved-op count (optional feature).
- stat_mispred  output  32  misprediction count (optional feature).

Behaviour:
- Address split:
  - TAGBITS = DBITS - BTB_IDX_BITS - 2.
  - idx = pc[BTB_IDX_BITS+1:2].
  - tag = pc[DBITS-1:BTB_IDX_BITS+2].
  - pc[1:0] is ignored.
- Entry contents: valid, tag, target[DBITS], ctr[CTR_BITS].
- Lookup (combinational, zero latency):
  - hit = valid[idx] & tag match.
  - predtaken_fe = hit & ctr MSB.
  - pcpred_fe = predtaken_fe ? target : pc_fe + INSTSIZE.
- Resolve (combinational):
  - pcgood_ex = upd_taken ? upd_target : upd_pc + INSTSIZE.
  - mispred_ex = upd_valid & (upd_pcpred != pcgood_ex).
  - Both outputs are meaningful only when upd_valid=1; pcgood_ex is still computed when upd_valid=0, and mispred_ex=0.
- Update (posedge clk, when upd_valid and not clear), at idx/tag of upd_pc:
  - Hit, conditional branch: ctr saturating +1 if taken, -1 if not taken. target <= upd_target if taken.
  - Hit, jump: ctr <= all-ones; target <= upd_target.
  - Miss, taken: allocate, overwriting any resident entry. valid=1, tag, target, ctr = 2^(CTR_BITS-1) (weakly taken); all-ones if jump.
  - Miss, not taken: no change.
- Saturation: ctr never wraps; all-ones +1 stays all-ones; 0 -1 stays 0.
- Same-cycle lookup and update to the same entry: lookup sees pre-edge contents; the new value is visible from the next cycle. No bypass.
- clear=1: all valid bits cleared at the edge. Overrides a simultaneous update; counters and targets are left as-is.
- reset (async):
  - All valid=0, all ctr = 2^(CTR_BITS-1)-1 (weakly not taken); targets/tags don't-care.
  - Stats = 0.
  - Outputs follow from the combinational equations: predtaken_fe=0, pcpred_fe=pc_fe+INSTSIZE, mispred_ex=0.
- Reset asserted mid-operation: tables invalidated immediately, and any update in that cycle is lost.
- Arithmetic: PC additions are modulo 2^DBITS; 0xFFFFFFFC+4 gives 0.

Optional Feature:
- Macro: BP_PERF_CTR_EN.
- Defined:
  - stat_upd increments on every upd_valid cycle; stat_mispred increments on every mispred_ex cycle.
  - Both saturate at 0xFFFFFFFF and are cleared by reset only (not by clear).
- Undefined: both ports are tied to 0 and no counter flops are built.

Test Plan:
- Reset then pc_fe=0x100 -> predtaken_fe=0, pcpred_fe=0x104.
- Branch at 0x120 predicted 0x124, resolved taken to 0x200 -> mispred_ex=1, pcgood_ex=0x200. Next cycle pc_fe=0x120 gives pcpred_fe=0x200, predtaken_fe=1 (ctr=2).
- Same branch resolved not-taken twice, with upd_pcpred=0x200 then 0x124:
  - First update: mispred_ex=1, pcgood_ex=0x124; ctr 2->1.
  - Second update: mispred_ex=0; ctr 1->0; lookup of 0x120 gives 0x124.
  - Three taken resolutions then raise ctr to 3 and saturate (a fourth leaves it at 3).
- Aliasing: entry for 0x120 valid, then JAL at 0x120 + 4*64 = 0x220 taken to 0x400 -> entry overwritten. Lookup 0x120 misses (pcpred 0x124); lookup 0x220 gives 0x400 with ctr=3.
- Same-cycle pc_fe=0x300 while the update allocating 0x300 fires -> that cycle pcpred_fe=0x304; next cycle gives the new target. clear asserted together with an update -> all entries invalid afterwards.
- With BP_PERF_CTR_EN: 5 updates, 2 mispredicts -> stat_upd=5, stat_mispred=2. Async reset pulse mid-sequence -> both 0 and all lookups miss.
